// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO and one-at-a-time issue sequencer
// feeding a combinational ALU, with a registered valid/ready result.
module alu_cmd_issue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              push_in,
  input  logic [3:0]        opcode_in,
  input  logic [7:0]        a_in,
  input  logic [7:0]        b_in,
  output logic              full_out,
  output logic              empty_out,
  output logic [ADDR_W:0]   count_out,
  output logic              overflow_out,
  output logic              alu_init_out,
  output logic [3:0]        alu_opcode_out,
  output logic [7:0]        alu_a_out,
  output logic [7:0]        alu_b_out,
  input  logic [15:0]       alu_result_in,
  output logic [15:0]       result_out,
  output logic [3:0]        result_opcode_out,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic [7:0]        op_count_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_t;

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  logic [3:0]        r_mem_op [DEPTH];
  logic [7:0]        r_mem_a  [DEPTH];
  logic [7:0]        r_mem_b  [DEPTH];
  logic [ADDR_W-1:0] r_wr;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;

  state_t            r_state;
  logic              r_init;
  logic [3:0]        r_op;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [15:0]       r_res;
  logic [3:0]        r_res_op;
  logic              r_valid;
  logic [7:0]        r_opcnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = push_in && !w_full;
  assign w_pop    = !w_empty &&
                    ((r_state == S_IDLE) ||
                     (r_state == S_HOLD && result_ready_in));
  // NOP, refresh and undefined opcodes leave the ALU output floating
  assign w_bypass = (r_op == 4'b0000) ||
                    (r_op == 4'b1011) ||
                    (r_op == 4'b1111);

  // FIFO storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (!rst_in && w_push) begin
      r_mem_op[r_wr] <= opcode_in;
      r_mem_a[r_wr]  <= a_in;
      r_mem_b[r_wr]  <= b_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
      if (push_in && w_full) r_ovf <= 1'b1;
    end
  end

  // Issue sequencer: pop, drive ALU for one cycle, capture, hold for ready
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_init   <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_res_op <= '0;
      r_valid  <= 1'b0;
      r_opcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op    <= r_mem_op[r_rd];
            r_a     <= r_mem_a[r_rd];
            r_b     <= r_mem_b[r_rd];
            r_init  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_init   <= 1'b0;
          r_res    <= w_bypass ? 16'h0000 : alu_result_in;
          r_res_op <= r_op;
          r_valid  <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          if (result_ready_in) begin
            r_opcnt <= r_opcnt + 8'd1;
            r_valid <= 1'b0;
            if (w_pop) begin
              r_op    <= r_mem_op[r_rd];
              r_a     <= r_mem_a[r_rd];
              r_b     <= r_mem_b[r_rd];
              r_init  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_init  <= 1'b0;
        end
      endcase
    end
  end

  assign full_out          = w_full;
  assign empty_out         = w_empty;
  assign count_out         = r_count;
  assign overflow_out      = r_ovf;
  assign alu_init_out      = r_init;
  assign alu_opcode_out    = r_op;
  assign alu_a_out         = r_a;
  assign alu_b_out         = r_b;
  assign result_out        = r_res;
  assign result_opcode_out = r_res_op;
  assign result_valid_out  = r_valid;
  assign op_count_out      = r_opcnt;

endmodule
